// File: rtl/iori_cmd_gen.sv
// Character-2 command generator: turns keyboard keycodes and hit pulses into
// animation FSM command levels/requests, closing the loop on state_out so that
// one-shot requests (attack, hurt) are held until the FSM acknowledges them.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// CMD_IDLE     | no attack in flight; a fresh attack press may be accepted
// CMD_ATK_REQ  | attack requested, waiting for state_out==1 or timeout
// CMD_COOLDOWN | attack acknowledged; presses ignored until cooldown expires
//
// Both timers are down-counters loaded on entry and decremented on frame
// edges; reaching the terminal count (1 -> done) ends the wait. cooldown_active
// tracks the cooldown state itself and is not masked by the hurt priority.
module iori_cmd_gen #(
  parameter logic [7:0] KEY_LEFT    = 8'h50,
  parameter logic [7:0] KEY_RIGHT   = 8'h4F,
  parameter logic [7:0] KEY_ATTACK  = 8'h28,
  parameter logic [7:0] KEY_DEFENSE = 8'h51,
  parameter logic [7:0] ACK_TIMEOUT = 8'd8,
  parameter logic [7:0] COOLDOWN    = 8'd20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       hit_in,
  input  logic [7:0] state_out,
  output logic       character2_attack,
  output logic       character2_move_r,
  output logic       character2_move_l,
  output logic       character2_defense,
  output logic       character2_hurt,
  output logic       cooldown_active
);

  typedef enum logic [1:0] {
    CMD_IDLE     = 2'd0,
    CMD_ATK_REQ  = 2'd1,
    CMD_COOLDOWN = 2'd2
  } cmd_state_t;

  cmd_state_t state, state_n;

  logic       frame_clk_q;
  logic       frame_edge;
  logic       key_attack_q;
  logic       hurt_pend, hurt_pend_n;
  logic [7:0] hurt_tmr, hurt_tmr_n;
  logic [7:0] atk_tmr, atk_tmr_n;

  logic key_left, key_right, key_attack, key_defense, atk_press;
  logic attack_n, move_r_n, move_l_n, defense_n, hurt_n, cooldown_n;

  assign key_left    = (keycode0 == KEY_LEFT)    | (keycode1 == KEY_LEFT);
  assign key_right   = (keycode0 == KEY_RIGHT)   | (keycode1 == KEY_RIGHT);
  assign key_attack  = (keycode0 == KEY_ATTACK)  | (keycode1 == KEY_ATTACK);
  assign key_defense = (keycode0 == KEY_DEFENSE) | (keycode1 == KEY_DEFENSE);
  assign atk_press   = key_attack & ~key_attack_q;

  // Frame-clock rising-edge detector and attack-key history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q  <= 1'b0;
      frame_edge   <= 1'b0;
      key_attack_q <= 1'b0;
    end else begin
      frame_clk_q  <= frame_clk;
      frame_edge   <= frame_clk & ~frame_clk_q;
      key_attack_q <= key_attack;
    end
  end

  // Hurt latch: a new hit (re)arms the timeout, acknowledge beats timeout.
  always_comb begin
    hurt_pend_n = hurt_pend;
    hurt_tmr_n  = hurt_tmr;
    if (hit_in) begin
      hurt_pend_n = 1'b1;
      hurt_tmr_n  = ACK_TIMEOUT;
    end else if (hurt_pend) begin
      if (state_out == 8'd5) begin
        hurt_pend_n = 1'b0;
        hurt_tmr_n  = 8'd0;
      end else if (frame_edge) begin
        if (hurt_tmr <= 8'd1) begin
          hurt_pend_n = 1'b0;
          hurt_tmr_n  = 8'd0;
        end else begin
          hurt_tmr_n = hurt_tmr - 8'd1;
        end
      end
    end
  end

  // Attack FSM next state; a pending hurt aborts or blocks an attack request.
  always_comb begin
    state_n   = state;
    atk_tmr_n = atk_tmr;
    case (state)
      CMD_IDLE: begin
        if (atk_press && !hurt_pend_n && !cooldown_active) begin
          state_n   = CMD_ATK_REQ;
          atk_tmr_n = ACK_TIMEOUT;
        end
      end
      CMD_ATK_REQ: begin
        if (hurt_pend_n) begin
          state_n   = CMD_IDLE;
          atk_tmr_n = 8'd0;
        end else if (state_out == 8'd1) begin
          state_n   = CMD_COOLDOWN;
          atk_tmr_n = COOLDOWN;
        end else if (frame_edge) begin
          if (atk_tmr <= 8'd1) begin
            state_n   = CMD_IDLE;
            atk_tmr_n = 8'd0;
          end else begin
            atk_tmr_n = atk_tmr - 8'd1;
          end
        end
      end
      CMD_COOLDOWN: begin
        if (frame_edge) begin
          if (atk_tmr <= 8'd1) begin
            state_n   = CMD_IDLE;
            atk_tmr_n = 8'd0;
          end else begin
            atk_tmr_n = atk_tmr - 8'd1;
          end
        end
      end
      default: begin
        state_n   = CMD_IDLE;
        atk_tmr_n = 8'd0;
      end
    endcase
  end

  // Output priority from next-cycle state: hurt, then attack, then levels.
  always_comb begin
    attack_n   = 1'b0;
    move_r_n   = 1'b0;
    move_l_n   = 1'b0;
    defense_n  = 1'b0;
    hurt_n     = 1'b0;
    cooldown_n = (state_n == CMD_COOLDOWN);
    if (hurt_pend_n) begin
      hurt_n = 1'b1;
    end else if (state_n == CMD_ATK_REQ) begin
      attack_n = 1'b1;
    end else begin
      move_r_n  = key_right & ~key_left;
      move_l_n  = key_left & ~key_right;
      defense_n = key_defense & ~key_left & ~key_right;
    end
  end

  // State, timers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state              <= CMD_IDLE;
      atk_tmr            <= 8'd0;
      hurt_pend          <= 1'b0;
      hurt_tmr           <= 8'd0;
      character2_attack  <= 1'b0;
      character2_move_r  <= 1'b0;
      character2_move_l  <= 1'b0;
      character2_defense <= 1'b0;
      character2_hurt    <= 1'b0;
      cooldown_active    <= 1'b0;
    end else begin
      state              <= state_n;
      atk_tmr            <= atk_tmr_n;
      hurt_pend          <= hurt_pend_n;
      hurt_tmr           <= hurt_tmr_n;
      character2_attack  <= attack_n;
      character2_move_r  <= move_r_n;
      character2_move_l  <= move_l_n;
      character2_defense <= defense_n;
      character2_hurt    <= hurt_n;
      cooldown_active    <= cooldown_n;
    end
  end

endmodule

// File: tb/tb_iori_cmd_gen.sv
// Scoreboard bench for iori_cmd_gen: stimulus pushes the reference model's
// expected output vector each cycle, a monitor pops and compares after each edge.
module tb_iori_cmd_gen;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic [7:0] keycode1 = 8'h00;
  logic       hit_in = 1'b0;
  logic [7:0] state_out = 8'h00;
  logic       character2_attack, character2_move_r, character2_move_l;
  logic       character2_defense, character2_hurt, cooldown_active;

  iori_cmd_gen dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode0(keycode0), .keycode1(keycode1), .hit_in(hit_in),
    .state_out(state_out),
    .character2_attack(character2_attack), .character2_move_r(character2_move_r),
    .character2_move_l(character2_move_l), .character2_defense(character2_defense),
    .character2_hurt(character2_hurt), .cooldown_active(cooldown_active)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [5:0] exp_q[$];

  // Reference model: "frames elapsed" bookkeeping of each pending obligation.
  bit p1, p2, m_ka_prev;
  bit m_hurt, m_req, m_cd;
  int m_hf, m_af, m_cdf;
  int hp = 2;
  int fc_cnt = 0;

  task automatic model_clear();
    p1 = 0; p2 = 0; m_ka_prev = 0;
    m_hurt = 0; m_req = 0; m_cd = 0;
    m_hf = 0; m_af = 0; m_cdf = 0;
  endtask

  task automatic step(input logic r, input logic [7:0] k0, input logic [7:0] k1,
                      input logic h, input logic [7:0] so);
    bit fe, ka, press, was_req, was_cd, kl, kr, kd;
    logic [5:0] e;
    @(negedge Clk);
    if (fc_cnt >= hp - 1) begin
      frame_clk = ~frame_clk;
      fc_cnt = 0;
    end else begin
      fc_cnt++;
    end
    Reset_n = r; keycode0 = k0; keycode1 = k1; hit_in = h; state_out = so;
    if (!r) begin
      model_clear();
      e = 6'b0;
    end else begin
      fe = p1 && !p2;
      p2 = p1;
      p1 = frame_clk;
      ka = (k0 == 8'h28) || (k1 == 8'h28);
      press = ka && !m_ka_prev;
      m_ka_prev = ka;
      if (h) begin
        m_hurt = 1; m_hf = 0;
      end else if (m_hurt) begin
        if (so == 8'd5) m_hurt = 0;
        else if (fe) begin
          m_hf++;
          if (m_hf == 8) m_hurt = 0;
        end
      end
      was_req = m_req;
      was_cd = m_cd;
      if (was_cd && fe) begin
        m_cdf++;
        if (m_cdf == 20) m_cd = 0;
      end
      if (was_req) begin
        if (m_hurt) m_req = 0;
        else if (so == 8'd1) begin
          m_req = 0; m_cd = 1; m_cdf = 0;
        end else if (fe) begin
          m_af++;
          if (m_af == 8) m_req = 0;
        end
      end else if (!was_cd && press && !m_hurt) begin
        m_req = 1; m_af = 0;
      end
      kl = (k0 == 8'h50) || (k1 == 8'h50);
      kr = (k0 == 8'h4F) || (k1 == 8'h4F);
      kd = (k0 == 8'h51) || (k1 == 8'h51);
      // {attack, move_r, move_l, defense, hurt, cooldown}
      if (m_hurt)     e = {5'b00001, m_cd};
      else if (m_req) e = {5'b10000, m_cd};
      else            e = {1'b0, kr && !kl, kl && !kr, kd && !kl && !kr, 1'b0, m_cd};
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per clock edge against the queued expectation.
  always @(posedge Clk) begin
    logic [5:0] act, e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {character2_attack, character2_move_r, character2_move_l,
             character2_defense, character2_hurt, cooldown_active};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b (atk,mr,ml,def,hurt,cd)",
                 cyc, act, e);
      end
    end
  end

  logic [7:0] keys [6];

  initial begin
    logic [7:0] k0, k1, so;
    logic h;
    int mode, len;
    keys[0] = 8'h00; keys[1] = 8'h50; keys[2] = 8'h4F;
    keys[3] = 8'h28; keys[4] = 8'h51; keys[5] = 8'h1A;
    model_clear();

    // reset with move-right held, then release
    repeat (3) step(0, 8'h4F, 8'h00, 0, 8'd0);
    repeat (3) step(1, 8'h4F, 8'h00, 0, 8'd0);
    // left+right conflict, then left alone
    repeat (3) step(1, 8'h50, 8'h4F, 0, 8'd0);
    repeat (3) step(1, 8'h50, 8'h00, 0, 8'd0);
    repeat (2) step(1, 8'h51, 8'h00, 0, 8'd0);
    // attack acknowledged 3 Clk after press, then cooldown with a re-press
    step(1, 8'h00, 8'h00, 0, 8'd0);
    repeat (3) step(1, 8'h28, 8'h00, 0, 8'd0);
    repeat (2) step(1, 8'h28, 8'h00, 0, 8'd1);
    repeat (10) step(1, 8'h00, 8'h00, 0, 8'd0);
    repeat (5) step(1, 8'h28, 8'h00, 0, 8'd0);
    repeat (80) step(1, 8'h00, 8'h00, 0, 8'd0);
    // unacknowledged attack times out; immediate re-press accepted
    repeat (45) step(1, 8'h00, 8'h28, 0, 8'd0);
    step(1, 8'h00, 8'h00, 0, 8'd0);
    repeat (4) step(1, 8'h00, 8'h28, 0, 8'd0);
    repeat (40) step(1, 8'h00, 8'h00, 0, 8'd0);
    // hit while moving right
    step(1, 8'h4F, 8'h00, 1, 8'd0);
    repeat (6) step(1, 8'h4F, 8'h00, 0, 8'd0);
    repeat (2) step(1, 8'h4F, 8'h00, 0, 8'd5);
    repeat (3) step(1, 8'h4F, 8'h00, 0, 8'd0);
    // hit and attack press together
    step(1, 8'h28, 8'h00, 1, 8'd0);
    repeat (3) step(1, 8'h28, 8'h00, 0, 8'd0);
    step(1, 8'h28, 8'h00, 0, 8'd5);
    repeat (4) step(1, 8'h28, 8'h00, 0, 8'd0);
    // hurt times out without acknowledge; second hit restarts it
    step(1, 8'h00, 8'h00, 1, 8'd0);
    repeat (20) step(1, 8'h00, 8'h00, 0, 8'd0);
    step(1, 8'h00, 8'h00, 1, 8'd0);
    repeat (40) step(1, 8'h00, 8'h00, 0, 8'd0);
    // reset in the middle of an attack request
    repeat (3) step(1, 8'h28, 8'h00, 0, 8'd0);
    repeat (2) step(0, 8'h28, 8'h00, 0, 8'd0);
    repeat (4) step(1, 8'h28, 8'h00, 0, 8'd0);

    // randomized segments
    k0 = 8'h00; k1 = 8'h00; so = 8'd0;
    for (int seg = 0; seg < 40; seg++) begin
      mode = $urandom_range(0, 2);
      hp = $urandom_range(1, 4);
      len = $urandom_range(40, 120);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) k0 = keys[$urandom_range(0, 5)];
        if ($urandom_range(0, 7) == 0) k1 = keys[$urandom_range(0, 5)];
        h = ($urandom_range(0, 59) == 0);
        case (mode)
          0: so = 8'd0;
          1: begin
            so = 8'd0;
            if (m_hurt && $urandom_range(0, 2) == 0) so = 8'd5;
            else if (m_req && $urandom_range(0, 2) == 0) so = 8'd1;
          end
          default: if ($urandom_range(0, 3) == 0) so = 8'($urandom_range(0, 5));
        endcase
        if ($urandom_range(0, 499) == 0) begin
          repeat (2) step(0, k0, k1, 0, so);
        end else begin
          step(1, k0, k1, h, so);
        end
      end
    end

    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
